ctrl_decode_seq: RTL and testbench
==================================

# ctrl_decode_seq

Registered, parametrised successor to the combinational MIPS control decoder. It sits between instruction fetch and the datapath and accepts one instruction per cycle through a valid/ready handshake. For each accepted instruction it issues a registered control word one cycle later. SYSCALL is handled by a stall FSM with a request/acknowledge handshake and a cycle-counted timeout, replacing any delay-based wait.

## Interface
- `ALUOP_W`, default 3: ALU op width, minimum 3. Encodings are zero-extended.
- `SYSCALL_WAIT`, default 8: maximum cycles in SYSCALL before timeout, ≥1.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `instr_valid` in 1: `instr` is valid this cycle.
- `instr` in 32: MIPS instruction word.
- `vreg` in 32: current $v0, the syscall code.
- `areg` in 32: current $a0, the syscall argument.
- `sc_ack` in 1: syscall service complete.
- `clr_trap` in 1: clears the trap state (only with `CTRL_ILLEGAL_TRAP_EN`).
- `ready` out 1: block accepts an instruction this cycle.
- `ctrl_valid` out 1: control word valid, exactly one cycle per accepted instruction.
- `reg_dst` out 2: 0 = rt, 1 = rd, 2 = $31.
- `jump`, `branch`, `mem_read`, `mem_to_reg`, `reg_write`, `alu_src`, `mem_write`, `jump_link`, `jump_reg` out 1 each: control word fields.
- `alu_op` out `ALUOP_W`: AND=0, OR=1, ADD=2, SUB=6, SLT=7.
- `stall` out 1: equals `!ready`.
- `sc_req` out 1: syscall request pending.
- `sc_code` out 32: latched `vreg`.
- `sc_arg` out 32: latched `areg`.
- `sc_timeout` out 1: one-cycle pulse when a syscall times out.
- `illegal` out 1: one-cycle pulse alongside `ctrl_valid` for an unsupported opcode or funct.
- `trap` out 1: high while in the TRAP state.

## Operation
- **Reset:** all outputs 0, FSM in RUN, counter 0. Because `ready` is a function of state (see below), it is 1 after reset.
- **FSM states:** RUN, SYSCALL, TRAP. `ready` = (state == RUN).
- **Accept:** an instruction is accepted when `instr_valid && ready`. The decoded word is registered, and `ctrl_valid` = 1 on the next cycle. With no accept, `ctrl_valid` = 0 and every control field is forced to 0.
- **Decode table:**
  - ADDI/ADDIU/LUI: ADD, `alu_src`, `reg_write`.
  - ORI: OR, `alu_src`, `reg_write`.
  - SLTIU: SLT, `alu_src`, `reg_write`.
  - LW: ADD, `alu_src`, `mem_read`, `mem_to_reg`, `reg_write`.
  - SW: ADD, `alu_src`, `mem_write`.
  - BEQ/BNE: SUB, `branch`.
  - J: `jump`.
  - JAL: `jump`, `jump_link`, `reg_dst` = 2, `reg_write`.
  - SPECIAL:
    - ADD/ADDU/SUB/AND/OR/SLT: `reg_dst` = 1, `reg_write`, matching ALU op.
    - JR: `jump_reg`.
    - funct 0: NOP (all fields 0).
    - SYSCALL: see below.
  - Anything else: all fields 0, and `illegal` = 1.
- **SYSCALL accept:** emits a NOP control word with `ctrl_valid` = 1. On the same edge, `sc_code` and `sc_arg` latch `vreg` and `areg`, `sc_req` goes to 1, the FSM moves to SYSCALL and the counter clears.
- **SYSCALL state:**
  - The counter increments each cycle.
  - If `sc_ack` is high: clear `sc_req` and return to RUN.
  - Otherwise, when the counter reaches `SYSCALL_WAIT`-1: clear `sc_req`, pulse `sc_timeout` for one cycle, and return to RUN.
  - If `sc_ack` arrives on the timeout cycle, it wins and no timeout pulse is produced.
  - `sc_code` and `sc_arg` hold until the next syscall.
- **Ignored inputs:** `sc_ack` outside SYSCALL has no effect. `instr_valid` while `ready` = 0 is ignored, and the fetch side must hold the instruction.
- **Reset mid-syscall:** returns to RUN with `sc_req` = 0 and no pending ack.

## Timing
- Decode latency is 1 cycle: instruction accepted on edge N, control word valid for the cycle after edge N.
- Throughput is 1 instruction per cycle in RUN.
- Syscall stall length is 1 to `SYSCALL_WAIT` cycles after the accept edge. `ready` returns to 1 on the cycle after the ack/timeout edge.
- `sc_ack` is sampled only on a rising edge while `sc_req` = 1.

## Configuration
- **`CTRL_ILLEGAL_TRAP_EN` defined:** an illegal instruction also moves the FSM to TRAP, where `trap` = 1 and `ready` = 0. TRAP exits to RUN one cycle after `clr_trap` = 1 is sampled. If `clr_trap` is high on the same edge as the illegal accept, the FSM still enters TRAP.
- **`CTRL_ILLEGAL_TRAP_EN` undefined:**
  - Illegal instructions only pulse `illegal` and are otherwise NOPs.
  - `trap` is tied to 0 and `clr_trap` is unused.
  - The TRAP state does not exist.

## Structure
- A shared package holds:
  - opcode and funct constants (ADDI, ORI, LW, SW, BEQ, BNE, J, JAL, ADDIU, SLTIU, LUI, SPECIAL, ADD, ADDU, SUB, AND, OR, SLT, JR, SYSCALL);
  - the ALU op encodings;
  - the FSM state enum;
  - the control-word struct.
- One sub-module, `ctrl_decode_comb`: a pure combinational map from `instr` to control word plus `is_syscall` and `is_illegal`.
- The top level holds the registers, the FSM and the counter.

## Test plan
- Reset, then LW 0x8C820004 with `instr_valid` = 1 → next cycle `ctrl_valid` = 1, `alu_op` = 2, and `mem_read`, `mem_to_reg`, `reg_write`, `alu_src` = 1.
- Back-to-back ADD (0x00851020), JAL (0x0C000010), BEQ (0x10850003) → three consecutive `ctrl_valid` cycles:
  - ADD: `reg_dst` = 1;
  - JAL: `reg_dst` = 2, `jump_link` = 1;
  - BEQ: `branch` = 1, `alu_op` = 6.
- SYSCALL (0x0000000C) with `vreg` = 4 and `areg` = 0x1000, `sc_ack` on the third cycle → `sc_code` = 4, `sc_arg` = 0x1000; `ready` = 0 for 3 cycles, then 1; no `sc_timeout`.
- SYSCALL with no ack and `SYSCALL_WAIT` = 8 → `sc_req` high for 8 cycles, `sc_timeout` pulses once, then `ready` = 1.
- Opcode 0x3F → `illegal` pulse.
  - With `CTRL_ILLEGAL_TRAP_EN`: `trap` = 1 and `ready` = 0 until `clr_trap`.
  - Without it: the next instruction is accepted immediately.
- Assert `rst_n` = 0 mid-SYSCALL → all outputs go to 0 asynchronously; after release, `ready` = 1.

Source files
------------

// File: rtl/ctrl_decode_seq_pkg.sv
// Shared constants, FSM state and control-word types for the registered MIPS control decoder.
// The TRAP state exists only when CTRL_ILLEGAL_TRAP_EN is defined.
package ctrl_decode_seq_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTIU   = 6'h0B;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;

    localparam logic [5:0] FN_NOP     = 6'h00;
    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_SYSCALL = 6'h0C;
    localparam logic [5:0] FN_ADD     = 6'h20;
    localparam logic [5:0] FN_ADDU    = 6'h21;
    localparam logic [5:0] FN_SUB     = 6'h22;
    localparam logic [5:0] FN_AND     = 6'h24;
    localparam logic [5:0] FN_OR      = 6'h25;
    localparam logic [5:0] FN_SLT     = 6'h2A;

    localparam logic [2:0] ALU_AND = 3'd0;
    localparam logic [2:0] ALU_OR  = 3'd1;
    localparam logic [2:0] ALU_ADD = 3'd2;
    localparam logic [2:0] ALU_SUB = 3'd6;
    localparam logic [2:0] ALU_SLT = 3'd7;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_SYSCALL = 2'd1
`ifdef CTRL_ILLEGAL_TRAP_EN
        , ST_TRAP  = 2'd2
`endif
    } state_t;

    typedef struct packed {
        logic [1:0] reg_dst;
        logic       jump;
        logic       branch;
        logic       mem_read;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src;
        logic       mem_write;
        logic       jump_link;
        logic       jump_reg;
        logic [2:0] alu_op;
    } ctrl_word_t;

endpackage

// File: rtl/ctrl_decode_comb.sv
// Pure combinational instruction-to-control-word map, flagging SYSCALL and unsupported encodings.
module ctrl_decode_comb
    import ctrl_decode_seq_pkg::*;
(
    input  logic [31:0] instr,
    output ctrl_word_t  cw,
    output logic        is_syscall,
    output logic        is_illegal
);

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [19:0] unused_fields;

    assign opcode        = instr[31:26];
    assign funct         = instr[5:0];
    assign unused_fields = instr[25:6];

    always_comb begin
        cw         = '0;
        is_syscall = 1'b0;
        is_illegal = 1'b0;
        case (opcode)
            OP_ADDI, OP_ADDIU, OP_LUI: begin
                cw.alu_op = ALU_ADD; cw.alu_src = 1'b1; cw.reg_write = 1'b1;
            end
            OP_ORI: begin
                cw.alu_op = ALU_OR; cw.alu_src = 1'b1; cw.reg_write = 1'b1;
            end
            OP_SLTIU: begin
                cw.alu_op = ALU_SLT; cw.alu_src = 1'b1; cw.reg_write = 1'b1;
            end
            OP_LW: begin
                cw.alu_op = ALU_ADD; cw.alu_src = 1'b1; cw.mem_read = 1'b1;
                cw.mem_to_reg = 1'b1; cw.reg_write = 1'b1;
            end
            OP_SW: begin
                cw.alu_op = ALU_ADD; cw.alu_src = 1'b1; cw.mem_write = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                cw.alu_op = ALU_SUB; cw.branch = 1'b1;
            end
            OP_J: cw.jump = 1'b1;
            OP_JAL: begin
                cw.jump = 1'b1; cw.jump_link = 1'b1; cw.reg_dst = 2'd2; cw.reg_write = 1'b1;
            end
            OP_SPECIAL: begin
                case (funct)
                    FN_ADD, FN_ADDU, FN_SUB, FN_AND, FN_OR, FN_SLT: begin
                        cw.reg_dst   = 2'd1;
                        cw.reg_write = 1'b1;
                        case (funct)
                            FN_SUB:  cw.alu_op = ALU_SUB;
                            FN_AND:  cw.alu_op = ALU_AND;
                            FN_OR:   cw.alu_op = ALU_OR;
                            FN_SLT:  cw.alu_op = ALU_SLT;
                            default: cw.alu_op = ALU_ADD;
                        endcase
                    end
                    FN_JR:      cw.jump_reg = 1'b1;
                    FN_NOP:     ;
                    FN_SYSCALL: is_syscall = 1'b1;
                    default:    is_illegal = 1'b1;
                endcase
            end
            default: is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/ctrl_decode_seq.sv
// Registered MIPS control decoder with valid/ready intake and a SYSCALL stall FSM with ack/timeout.
// Optional CTRL_ILLEGAL_TRAP_EN: illegal instructions park the FSM in TRAP until clr_trap.
module ctrl_decode_seq
    import ctrl_decode_seq_pkg::*;
#(
    parameter int ALUOP_W      = 3,
    parameter int SYSCALL_WAIT = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               instr_valid,
    input  logic [31:0]        instr,
    input  logic [31:0]        vreg,
    input  logic [31:0]        areg,
    input  logic               sc_ack,
    input  logic               clr_trap,
    output logic               ready,
    output logic               ctrl_valid,
    output logic [1:0]         reg_dst,
    output logic               jump,
    output logic               branch,
    output logic               mem_read,
    output logic               mem_to_reg,
    output logic               reg_write,
    output logic               alu_src,
    output logic               mem_write,
    output logic               jump_link,
    output logic               jump_reg,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               stall,
    output logic               sc_req,
    output logic [31:0]        sc_code,
    output logic [31:0]        sc_arg,
    output logic               sc_timeout,
    output logic               illegal,
    output logic               trap
);

    localparam int               CNT_W    = $clog2(SYSCALL_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYSCALL_WAIT - 1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    ctrl_word_t       ctrl_reg, ctrl_next, dec_cw;
    logic             ctrl_valid_reg, ctrl_valid_next;
    logic             illegal_reg, illegal_next;
    logic             sc_req_reg, sc_req_next;
    logic             sc_timeout_reg, sc_timeout_next;
    logic [31:0]      sc_code_reg, sc_code_next;
    logic [31:0]      sc_arg_reg, sc_arg_next;
    logic             dec_syscall, dec_illegal, accept;

    ctrl_decode_comb u_decode (
        .instr      (instr),
        .cw         (dec_cw),
        .is_syscall (dec_syscall),
        .is_illegal (dec_illegal)
    );

    assign ready  = (state_reg == ST_RUN);
    assign stall  = ~ready;
    assign accept = instr_valid && ready;

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        sc_req_next     = sc_req_reg;
        sc_timeout_next = 1'b0;
        sc_code_next    = sc_code_reg;
        sc_arg_next     = sc_arg_reg;
        // Idle cycles present an all-zero control word, not a stale one.
        ctrl_next       = accept ? dec_cw : '0;
        ctrl_valid_next = accept;
        illegal_next    = accept && dec_illegal;
        case (state_reg)
            ST_RUN: begin
                if (accept && dec_syscall) begin
                    state_next   = ST_SYSCALL;
                    cnt_next     = '0;
                    sc_req_next  = 1'b1;
                    sc_code_next = vreg;
                    sc_arg_next  = areg;
                end
`ifdef CTRL_ILLEGAL_TRAP_EN
                else if (accept && dec_illegal) begin
                    state_next = ST_TRAP;
                end
`endif
            end
            ST_SYSCALL: begin
                // An ack on the final counted cycle takes priority over the timeout.
                if (sc_ack) begin
                    sc_req_next = 1'b0;
                    state_next  = ST_RUN;
                end else if (cnt_reg == CNT_LAST) begin
                    sc_req_next     = 1'b0;
                    sc_timeout_next = 1'b1;
                    state_next      = ST_RUN;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
`ifdef CTRL_ILLEGAL_TRAP_EN
            ST_TRAP: begin
                if (clr_trap) state_next = ST_RUN;
            end
`endif
            default: state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_RUN;
            cnt_reg        <= '0;
            ctrl_reg       <= '0;
            ctrl_valid_reg <= 1'b0;
            illegal_reg    <= 1'b0;
            sc_req_reg     <= 1'b0;
            sc_timeout_reg <= 1'b0;
            sc_code_reg    <= '0;
            sc_arg_reg     <= '0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            ctrl_reg       <= ctrl_next;
            ctrl_valid_reg <= ctrl_valid_next;
            illegal_reg    <= illegal_next;
            sc_req_reg     <= sc_req_next;
            sc_timeout_reg <= sc_timeout_next;
            sc_code_reg    <= sc_code_next;
            sc_arg_reg     <= sc_arg_next;
        end
    end

    assign ctrl_valid = ctrl_valid_reg;
    assign reg_dst    = ctrl_reg.reg_dst;
    assign jump       = ctrl_reg.jump;
    assign branch     = ctrl_reg.branch;
    assign mem_read   = ctrl_reg.mem_read;
    assign mem_to_reg = ctrl_reg.mem_to_reg;
    assign reg_write  = ctrl_reg.reg_write;
    assign alu_src    = ctrl_reg.alu_src;
    assign mem_write  = ctrl_reg.mem_write;
    assign jump_link  = ctrl_reg.jump_link;
    assign jump_reg   = ctrl_reg.jump_reg;
    assign alu_op     = ALUOP_W'(ctrl_reg.alu_op);
    assign illegal    = illegal_reg;
    assign sc_req     = sc_req_reg;
    assign sc_code    = sc_code_reg;
    assign sc_arg     = sc_arg_reg;
    assign sc_timeout = sc_timeout_reg;

`ifdef CTRL_ILLEGAL_TRAP_EN
    assign trap = (state_reg == ST_TRAP);
`else
    logic unused_clr_trap;
    assign unused_clr_trap = clr_trap;
    assign trap = 1'b0;
`endif

endmodule

// File: tb/tb_ctrl_decode_seq.sv
// Scoreboard bench for ctrl_decode_seq: expected control words are queued at drive time, popped at output.
module tb_ctrl_decode_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic [31:0] instr = '0;
    logic [31:0] vreg = '0;
    logic [31:0] areg = '0;
    logic        sc_ack = 1'b0;
    logic        clr_trap = 1'b0;
    logic        ready, ctrl_valid, jump, branch, mem_read, mem_to_reg, reg_write;
    logic        alu_src, mem_write, jump_link, jump_reg, stall, sc_req, sc_timeout, illegal, trap;
    logic [1:0]  reg_dst;
    logic [2:0]  alu_op;
    logic [31:0] sc_code, sc_arg;
    logic [15:0] dut_word;

    logic [15:0] sb[$];
    int checks = 0;
    int errors = 0;

    ctrl_decode_seq #(.ALUOP_W(3), .SYSCALL_WAIT(8)) dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
        .vreg(vreg), .areg(areg), .sc_ack(sc_ack), .clr_trap(clr_trap),
        .ready(ready), .ctrl_valid(ctrl_valid), .reg_dst(reg_dst), .jump(jump),
        .branch(branch), .mem_read(mem_read), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .alu_src(alu_src), .mem_write(mem_write),
        .jump_link(jump_link), .jump_reg(jump_reg), .alu_op(alu_op), .stall(stall),
        .sc_req(sc_req), .sc_code(sc_code), .sc_arg(sc_arg), .sc_timeout(sc_timeout),
        .illegal(illegal), .trap(trap)
    );

    always #5 clk = ~clk;

    assign dut_word = {ctrl_valid, reg_dst, jump, branch, mem_read, mem_to_reg, reg_write,
                       alu_src, mem_write, jump_link, jump_reg, alu_op, illegal};

    // Reference decode straight from the instruction table; result is the expected accepted word.
    function automatic logic [15:0] model(input logic [31:0] i);
        logic [5:0] op, fn;
        logic [1:0] rd;
        logic [2:0] a;
        logic j, b, mr, mtr, rw, as, mw, jl, jr, il;
        op = i[31:26]; fn = i[5:0];
        rd = 2'd0; a = 3'd0;
        {j, b, mr, mtr, rw, as, mw, jl, jr, il} = '0;
        case (op)
            6'h08, 6'h09, 6'h0F: begin a = 3'd2; as = 1; rw = 1; end
            6'h0D: begin a = 3'd1; as = 1; rw = 1; end
            6'h0B: begin a = 3'd7; as = 1; rw = 1; end
            6'h23: begin a = 3'd2; as = 1; mr = 1; mtr = 1; rw = 1; end
            6'h2B: begin a = 3'd2; as = 1; mw = 1; end
            6'h04, 6'h05: begin a = 3'd6; b = 1; end
            6'h02: j = 1;
            6'h03: begin j = 1; jl = 1; rd = 2'd2; rw = 1; end
            6'h00: begin
                case (fn)
                    6'h20, 6'h21: begin rd = 1; rw = 1; a = 3'd2; end
                    6'h22: begin rd = 1; rw = 1; a = 3'd6; end
                    6'h24: begin rd = 1; rw = 1; a = 3'd0; end
                    6'h25: begin rd = 1; rw = 1; a = 3'd1; end
                    6'h2A: begin rd = 1; rw = 1; a = 3'd7; end
                    6'h08: jr = 1;
                    6'h00, 6'h0C: ;
                    default: il = 1;
                endcase
            end
            default: il = 1;
        endcase
        return {1'b1, rd, j, b, mr, mtr, rw, as, mw, jl, jr, a, il};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (dut_word !== 16'h0) begin errors++; $display("FAIL reset_word: got %h want 0000", dut_word); end
        checks++; if ({sc_req, sc_timeout, trap, stall} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b want 0000", {sc_req, sc_timeout, trap, stall}); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ready); end
        checks++; if ({sc_code, sc_arg} !== 64'h0) begin errors++; $display("FAIL reset_sc: got %h want 0", {sc_code, sc_arg}); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_lw();
        logic [15:0] exp;
        instr = 32'h8C820004; instr_valid = 1'b1; sb.push_back(model(instr));
        @(negedge clk);
        instr_valid = 1'b0;
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL lw_word: no expected entry, got %h", dut_word); end
        else begin
            exp = sb.pop_front();
            $display("txn lw instr=8c820004 word=%h", dut_word);
            if (dut_word !== exp) begin errors++; $display("FAIL lw_word: got %h want %h", dut_word, exp); end
        end
        @(negedge clk);
        checks++; if (dut_word !== 16'h0) begin errors++; $display("FAIL lw_idle: got %h want 0000", dut_word); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] list [3] = '{32'h00851020, 32'h0C000010, 32'h10850003};
        logic [15:0] exp;
        for (int i = 0; i <= 3; i++) begin
            if (i > 0) begin
                checks++;
                if (sb.size() == 0) begin errors++; $display("FAIL b2b_word: no expected entry, got %h", dut_word); end
                else begin
                    exp = sb.pop_front();
                    $display("txn b2b instr=%h word=%h", list[i-1], dut_word);
                    if (dut_word !== exp) begin errors++; $display("FAIL b2b_word: instr %h got %h want %h", list[i-1], dut_word, exp); end
                end
                checks++; if (ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b want 1", ready); end
            end
            if (i < 3) begin instr = list[i]; instr_valid = 1'b1; sb.push_back(model(list[i])); end
            else instr_valid = 1'b0;
            @(negedge clk);
        end
        checks++; if (ctrl_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b want 0", ctrl_valid); end
    endtask

    task automatic test_decode_table();
        logic [31:0] list [15] = '{32'h34A5000F, 32'h2CA50001, 32'hAC820004, 32'h14850003,
                                   32'h08000010, 32'h03E00008, 32'h00000000, 32'h00851021,
                                   32'h00851022, 32'h00851024, 32'h00851025, 32'h0085102A,
                                   32'h20A50001, 32'h24A50001, 32'h3C051234};
        logic [15:0] exp;
        for (int i = 0; i <= 15; i++) begin
            if (i > 0) begin
                checks++;
                if (sb.size() == 0) begin errors++; $display("FAIL table_word: no expected entry, got %h", dut_word); end
                else begin
                    exp = sb.pop_front();
                    $display("txn table instr=%h word=%h", list[i-1], dut_word);
                    if (dut_word !== exp) begin errors++; $display("FAIL table_word: instr %h got %h want %h", list[i-1], dut_word, exp); end
                end
            end
            if (i < 15) begin instr = list[i]; instr_valid = 1'b1; sb.push_back(model(list[i])); end
            else instr_valid = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_syscall_ack();
        logic [15:0] exp;
        int low_cnt = 0;
        int to_cnt = 0;
        vreg = 32'd4; areg = 32'h1000;
        instr = 32'h0000000C; instr_valid = 1'b1; sb.push_back(model(instr));
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 1) begin
                instr_valid = 1'b0; vreg = 32'd99; areg = 32'hDEAD;
                checks++;
                if (sb.size() == 0) begin errors++; $display("FAIL sc_word: no expected entry, got %h", dut_word); end
                else begin
                    exp = sb.pop_front();
                    $display("txn syscall instr=0000000c word=%h", dut_word);
                    if (dut_word !== exp) begin errors++; $display("FAIL sc_word: got %h want %h", dut_word, exp); end
                end
                checks++; if (sc_req !== 1'b1) begin errors++; $display("FAIL sc_req_set: got %b want 1", sc_req); end
            end
            if (ready === 1'b0) low_cnt++;
            if (sc_timeout === 1'b1) to_cnt++;
            sc_ack = (c == 3);
        end
        sc_ack = 1'b0;
        checks++; if (low_cnt != 3) begin errors++; $display("FAIL sc_stall_len: got %0d want 3", low_cnt); end
        checks++; if (ready !== 1'b1 || sc_req !== 1'b0) begin errors++; $display("FAIL sc_release: got ready=%b req=%b want 1/0", ready, sc_req); end
        checks++; if (to_cnt != 0) begin errors++; $display("FAIL sc_no_timeout: got %0d pulses want 0", to_cnt); end
        checks++; if (sc_code !== 32'd4 || sc_arg !== 32'h1000) begin errors++; $display("FAIL sc_latch: got %h/%h want 4/1000", sc_code, sc_arg); end
        @(negedge clk);
    endtask

    task automatic test_syscall_timeout();
        int req_cnt = 0;
        int to_cnt = 0;
        vreg = 32'd10; areg = 32'h55;
        instr = 32'h0000000C; instr_valid = 1'b1; sb.push_back(model(instr));
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            instr_valid = 1'b0;
            if (c == 1) begin
                checks++;
                if (sb.size() == 0) begin errors++; $display("FAIL to_word: no expected entry"); end
                else if (dut_word !== sb.pop_front()) begin errors++; $display("FAIL to_word: got %h want nop word", dut_word); end
            end
            if (sc_req === 1'b1) req_cnt++;
            if (sc_timeout === 1'b1) to_cnt++;
            checks++;
            if (ready !== (c >= 9) || sc_timeout !== (c == 9)) begin
                errors++; $display("FAIL to_cycle: cycle %0d got ready=%b to=%b want %b/%b", c, ready, sc_timeout, c >= 9, c == 9);
            end
            sc_ack = (c == 10);
        end
        sc_ack = 1'b0;
        $display("txn syscall_timeout req_cycles=%0d pulses=%0d", req_cnt, to_cnt);
        checks++; if (req_cnt != 8) begin errors++; $display("FAIL to_req_len: got %0d want 8", req_cnt); end
        checks++; if (to_cnt != 1) begin errors++; $display("FAIL to_pulses: got %0d want 1", to_cnt); end
        checks++; if (sc_req !== 1'b0 || sc_code !== 32'd10) begin errors++; $display("FAIL to_stray_ack: got req=%b code=%h want 0/a", sc_req, sc_code); end
    endtask

    task automatic test_illegal();
        logic [15:0] exp;
        instr = 32'hFC000000; instr_valid = 1'b1; sb.push_back(model(instr));
        @(negedge clk);
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL ill_word: no expected entry"); end
        else begin
            exp = sb.pop_front();
            $display("txn illegal instr=fc000000 word=%h", dut_word);
            if (dut_word !== exp) begin errors++; $display("FAIL ill_word: got %h want %h", dut_word, exp); end
        end
`ifdef CTRL_ILLEGAL_TRAP_EN
        instr_valid = 1'b0;
        @(negedge clk);
        checks++; if (trap !== 1'b1 || ready !== 1'b0) begin errors++; $display("FAIL ill_trap: got trap=%b ready=%b want 1/0", trap, ready); end
        clr_trap = 1'b1;
        @(negedge clk);
        clr_trap = 1'b0;
        checks++; if (trap !== 1'b0 || ready !== 1'b1) begin errors++; $display("FAIL ill_clear: got trap=%b ready=%b want 0/1", trap, ready); end
`else
        checks++; if (trap !== 1'b0 || ready !== 1'b1) begin errors++; $display("FAIL ill_ready: got trap=%b ready=%b want 0/1", trap, ready); end
        instr = 32'h34A5000F; sb.push_back(model(instr));
        @(negedge clk);
        instr_valid = 1'b0;
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL ill_next: no expected entry"); end
        else begin
            exp = sb.pop_front();
            $display("txn after_illegal instr=34a5000f word=%h", dut_word);
            if (dut_word !== exp) begin errors++; $display("FAIL ill_next: got %h want %h", dut_word, exp); end
        end
`endif
        @(negedge clk);
    endtask

    task automatic test_reset_mid_syscall();
        logic [15:0] exp;
        vreg = 32'd7; areg = 32'h77;
        instr = 32'h0000000C; instr_valid = 1'b1; sb.push_back(model(instr));
        @(negedge clk);
        instr_valid = 1'b0;
        if (sb.size() != 0) exp = sb.pop_front();
        @(negedge clk);
        checks++; if (sc_req !== 1'b1 || ready !== 1'b0) begin errors++; $display("FAIL mid_pre: got req=%b ready=%b want 1/0", sc_req, ready); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (sc_req !== 1'b0 || dut_word !== 16'h0 || sc_code !== 32'h0) begin errors++; $display("FAIL mid_async: got req=%b word=%h code=%h want 0", sc_req, dut_word, sc_code); end
        @(negedge clk);
        rst_n = 1'b1;
        sc_ack = 1'b1;
        @(negedge clk);
        sc_ack = 1'b0;
        checks++; if (ready !== 1'b1 || sc_req !== 1'b0) begin errors++; $display("FAIL mid_release: got ready=%b req=%b want 1/0", ready, sc_req); end
        instr = 32'h20A50001; instr_valid = 1'b1; sb.push_back(model(instr));
        @(negedge clk);
        instr_valid = 1'b0;
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL mid_next: no expected entry"); end
        else begin
            exp = sb.pop_front();
            $display("txn after_reset instr=20a50001 word=%h", dut_word);
            if (dut_word !== exp) begin errors++; $display("FAIL mid_next: got %h want %h", dut_word, exp); end
        end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL sb_drain: got %0d left want 0", sb.size()); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_lw();
        test_back_to_back();
        test_decode_table();
        test_syscall_ack();
        test_syscall_timeout();
        test_illegal();
        test_reset_mid_syscall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
